// File: rtl/pbl_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : pbl_input_conditioner_if
// Description : Raw switch/button inputs and committed outputs for two users.
// Revision    : 1.0 - initial release
// ============================================================================
interface pbl_input_conditioner_if;
    logic [3:0] HH0_RAW;
    logic [1:0] B0_RAW;
    logic [3:0] HH1_RAW;
    logic [1:0] B1_RAW;
    logic [3:0] HH0;
    logic [1:0] B0;
    logic [3:0] HH1;
    logic [1:0] B1;
    logic       REQ0;
    logic       REQ1;
    logic [1:0] SETTLING;

    modport master (
        output HH0_RAW, B0_RAW, HH1_RAW, B1_RAW,
        input  HH0, B0, HH1, B1, REQ0, REQ1, SETTLING
    );

    modport slave (
        input  HH0_RAW, B0_RAW, HH1_RAW, B1_RAW,
        output HH0, B0, HH1, B1, REQ0, REQ1, SETTLING
    );
endinterface
`default_nettype wire

// File: rtl/pbl_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pbl_input_conditioner
// Description : Two-flop sync plus per-user debounce; commits stable words.
// Revision    : 1.0 - initial release
// ============================================================================
module pbl_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    pbl_input_conditioner_if.slave io
);

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 255)) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must lie in 2..255");
    end
    if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    localparam logic             c_IDLE     = 1'b0;
    localparam logic             c_SETTLE   = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0][5:0] w_raw;
    logic [1:0][5:0] r_sync1;
    logic [1:0][5:0] r_sync2;
    logic [1:0][5:0] w_commit;
    logic [1:0]      w_req;
    logic [1:0]      w_settling;

    assign w_raw[0] = {io.HH0_RAW, io.B0_RAW};
    assign w_raw[1] = {io.HH1_RAW, io.B1_RAW};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar u = 0; u < 2; u++) begin : g_user
        logic             r_state;
        logic             w_state_nxt;
        logic [5:0]       r_commit;
        logic [5:0]       w_commit_nxt;
        logic [5:0]       r_snap;
        logic [5:0]       w_snap_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_req;
        logic             w_req_nxt;
        logic             w_settle_out;
        logic [5:0]       w_word;

        assign w_word = r_sync2[u];

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_state  <= c_IDLE;
                r_commit <= '0;
                r_snap   <= '0;
                r_cnt    <= '0;
                r_req    <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_commit <= w_commit_nxt;
                r_snap   <= w_snap_nxt;
                r_cnt    <= w_cnt_nxt;
                r_req    <= w_req_nxt;
            end
        end

        always_comb begin
            w_state_nxt  = r_state;
            w_commit_nxt = r_commit;
            w_snap_nxt   = r_snap;
            w_cnt_nxt    = r_cnt;
            w_req_nxt    = 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_word != r_commit) begin
                        w_state_nxt = c_SETTLE;
                        w_snap_nxt  = w_word;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
                c_SETTLE: begin
                    if (w_word == r_snap) begin
                        if (r_cnt == c_CNT_LAST) begin
                            w_commit_nxt = r_snap;
                            w_req_nxt    = 1'b1;
                            w_state_nxt  = c_IDLE;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end else if (w_word == r_commit) begin
                        // Bounced back to the committed value: abandon quietly
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_snap_nxt = w_word;
                        w_cnt_nxt  = c_CNT_ONE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end

        always_comb begin
            w_settle_out = (r_state == c_SETTLE);
        end

        assign w_commit[u]   = r_commit;
        assign w_req[u]      = r_req;
        assign w_settling[u] = w_settle_out;
    end

    assign io.HH0      = w_commit[0][5:2];
    assign io.B0       = w_commit[0][1:0];
    assign io.HH1      = w_commit[1][5:2];
    assign io.B1       = w_commit[1][1:0];
    assign io.REQ0     = w_req[0];
    assign io.REQ1     = w_req[1];
    assign io.SETTLING = w_settling;

endmodule
`default_nettype wire

// File: doc/pbl_input_conditioner.md
Name: pbl_input_conditioner

Overview:
Input front end for the access-control datapath (authentication, functionality, terminal selection, LED/matrix decode). It samples the two users' raw switch words (HH0/HH1) and button pairs (B0/B1), synchronizes and debounces them per user, and presents glitch-free registered words to the combinational stage downstream. A one-cycle REQ pulse per user marks each newly committed request, so later stages can register or log it.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive identical synchronized samples required before a user word is committed; legal range 2..255, elaboration error outside it.
CNT_W, 8, stability counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
CLK  in  1  single system clock; all state updates on rising edge.
RST  in  1  synchronous, active-high reset.
HH0_RAW  in  4  user 0 raw switches (asynchronous to CLK).
B0_RAW  in  2  user 0 raw buttons (asynchronous).
HH1_RAW  in  4  user 1 raw switches (asynchronous).
B1_RAW  in  2  user 1 raw buttons (asynchronous).
HH0  out  4  user 0 committed switches, registered.
B0  out  2  user 0 committed buttons, registered.
HH1  out  4  user 1 committed switches, registered.
B1  out  2  user 1 committed buttons, registered.
REQ0  out  1  one-cycle pulse, user 0 word committed with a new value.
REQ1  out  1  one-cycle pulse, user 1 word committed with a new value.
SETTLING  out  2  bit u high while user u is in SETTLE.

Behaviour:
- Synchronizer: every raw bit passes through two flops (s1, s2). No logic between them. Per user, W_u = {HHu_RAW, Bu_RAW} after s2 (6 bits).
- Per user, independent state: committed word C_u, which drives HHu and Bu; snapshot S_u; counter cnt_u; FSM state IDLE or SETTLE.
- Reset (RST high at an edge): s1, s2, C, S, cnt all 0; state IDLE; HH0, HH1, B0, B1 = 0; REQ0 = REQ1 = 0; SETTLING = 0. Reset overrides everything, including mid-SETTLE, and no REQ pulse is produced by reset.
- IDLE:
  - W_u == C_u: stay.
  - W_u != C_u: go to SETTLE, S_u <= W_u, cnt_u <= 1.
- SETTLE:
  - W_u == S_u and cnt_u == DEBOUNCE_CYCLES-1: C_u <= S_u, REQu <= 1 for exactly the next cycle, go to IDLE, cnt_u <= 0.
  - W_u == S_u otherwise: cnt_u <= cnt_u+1.
  - W_u != S_u and W_u == C_u: bounce back to the old value; go to IDLE, cnt_u <= 0, no REQ.
  - W_u != S_u and W_u != C_u: restart; S_u <= W_u, cnt_u <= 1, stay in SETTLE.
- The counter never exceeds DEBOUNCE_CYCLES-1. No wrap is possible.
- Latency: if raw inputs change just before edge k and then stay stable, s2 shows the change after edge k+1, SETTLE is entered at edge k+2, and C/REQ update at edge k+DEBOUNCE_CYCLES+1. Total is DEBOUNCE_CYCLES+1 edges.
- REQ is registered and high for one cycle per commit. A commit always carries a value different from the previous C (guaranteed by entry into SETTLE).
- Users are fully independent. Simultaneous commits on both users assert REQ0 and REQ1 in the same cycle.
- Outputs change only at commit or reset. They never show intermediate or bouncing values.

Test Plan:
- Reset: hold RST 3 cycles with raw = all 1s -> all outputs 0, SETTLING = 0. Release RST -> with DEBOUNCE_CYCLES=4, HH0=4'hF and B0=2'b11 appear at edge k+5, REQ0 high exactly 1 cycle.
- Clean change, DEBOUNCE_CYCLES=4: HH1_RAW 0->4'b1010 -> HH1=4'b1010 after 5 edges, REQ1 pulse once, SETTLING[1] high for cycles k+2..k+4, HH0/B0/REQ0 unaffected.
- Bounce to old value: B0_RAW 00->01 for 2 cycles then back to 00 -> B0 stays 00, REQ0 never asserts, SETTLING[0] drops.
- Bounce to third value: HH0_RAW 0->3 for 2 cycles, then 5 held -> HH0 goes straight to 5, 4 stable samples after the 5 reaches s2; value 3 never appears; one REQ0.
- Simultaneous users: both raw words change on the same edge -> REQ0 and REQ1 pulse in the same cycle, both words correct.
- Reset mid-SETTLE: assert RST while cnt=2 -> outputs 0, IDLE. Raw held nonzero -> a full new debounce starts after release, with exactly one REQ.
